// File: rtl/fsm_debounce_filter.sv
// fsm_debounce_filter: synchronises a raw level and debounces it into out with rise/fall/glitch strobes
module fsm_debounce_filter #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall,
   output logic glitch
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] STABLE_LO = 2'b00;
   localparam logic [1:0] CHK_HI    = 2'b01;
   localparam logic [1:0] STABLE_HI = 2'b10;
   localparam logic [1:0] CHK_LO    = 2'b11;
   logic [SYNC_STAGES-1:0] sync;
   logic [1:0] state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic s, diff, accept, abort;
   assign s = sync[SYNC_STAGES-1];
   // bit 1 of the state encoding is the debounced level, so out is the state flop itself
   assign out = state[1];
   // synchroniser chain, forced to the reset level so no spurious change follows reset
   always_ff @(posedge clk)
      if (reset) sync <= {SYNC_STAGES{RESET_LEVEL}};
      else sync <= {sync[SYNC_STAGES-2:0], in};
   // stable states hold cnt at 0, so one compare against N-1 covers both the N==1 and counting cases
   always_comb begin
      diff    = s != out;
      accept  = diff && cnt == LAST;
      abort   = state[0] && !diff;
      state_n = accept ? (out ? STABLE_LO : STABLE_HI) :
                abort  ? (out ? STABLE_HI : STABLE_LO) :
                diff   ? (out ? CHK_LO : CHK_HI) : state;
      cnt_n   = diff && !accept ? cnt + CW'(1) : '0;
   end
   // state, counter and registered strobes
   always_ff @(posedge clk)
      if (reset) begin
         state  <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         glitch <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rise   <= accept && !out;
         fall   <= accept && out;
         glitch <= abort;
      end
endmodule
